datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Minimal integer datapath: NREGS x LENGTH register file, two-operand ALU, one registered result stage.
- Sits under the control unit, which drives register addresses, the write enable, the immediate and the function select.
- Supports LUI (pass immediate) and ADD (A+B) today.
- Results reach the register file through the registered result stage and the write port.

Parameters:
- LENGTH, 32, datapath/register width in bits
- NREGS, 32, number of architectural registers
- SEL_BITS, $clog2(NREGS), register address width (derived; not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addr_a  input  SEL_BITS  read address, operand A
- addr_b  input  SEL_BITS  read address, operand B
- addr_d  input  SEL_BITS  write (destination) address
- wr_regfile  input  1  register file write enable
- imm  input  LENGTH  immediate operand
- f  input  1  function select: 1 = LUI (pass imm), 0 = ADD (A+B)
- data_a  output  LENGTH  combinational read of regfile[addr_a]
- data_b  output  LENGTH  combinational read of regfile[addr_b]
- result  output  LENGTH  registered ALU result, also the write data

Behaviour:
- Reset:
  - On a rising edge with reset=1, all NREGS registers and `result` clear to 0.
  - Reset has priority over a simultaneous write; no write occurs that cycle.
- Register file:
  - Reads are asynchronous: data_a and data_b follow the addresses and contents combinationally.
  - Write is synchronous: on a rising edge with reset=0 and wr_regfile=1, regfile[addr_d] <= result.
  - Register 0 is an ordinary writable register, not hardwired to zero.
- ALU (combinational):
  - alu = imm when f=1.
  - alu = data_a + data_b when f=0, modulo 2^LENGTH; carry out discarded, no overflow flag.
  - An X/undriven f or imm leaves the ALU output unspecified; `result` is 0 only immediately after reset.
- Result stage:
  - `result` <= alu on every rising edge with reset=0. No enable; it captures every cycle.
  - Latency: operands/imm/f stable before edge N -> visible on `result` after edge N -> written to regfile at edge N+1 if wr_regfile=1 at that edge.
  - The control unit holds operand/function inputs for one cycle (ALU stage), then asserts wr_regfile with addr_d (WR stage).
- Write data is always `result` (the previous cycle's ALU value), not the same-cycle ALU output.
- Read/write hazard:
  - When addr_d equals addr_a or addr_b during a write, data_a/data_b show the old value until the edge, then the new value.
  - There is no internal forwarding.
- Back-to-back writes to different addresses on consecutive cycles are legal; each writes the `result` present at its edge.
- wr_regfile=0 leaves all registers unchanged regardless of addr_d.

Test Plan:
- Reset: write nonzero values, assert reset 1 cycle -> all registers read 0 via data_a/data_b, result=0; assert reset together with wr_regfile=1 -> no register changes.
- LUI: f=1, imm=0xCAC00000, wait 1 edge -> result=0xCAC00000; wr_regfile=1, addr_d=0, 1 edge -> addr_a=0 reads 0xCAC00000 (register 0 writable).
- Second LUI: f=1, imm=0x01000000 -> result=0x01000000; write to r1 -> data_b with addr_b=1 reads 0x01000000; r0 still 0xCAC00000.
- ADD: f=0, addr_a=0, addr_b=1, 1 edge -> result=0xCBC00000; write addr_d=2 -> r2=0xCBC00000; r0 and r1 unchanged.
- Wrap-around: r3=0xFFFFFFFF, r4=0x00000002, ADD -> result=0x00000001; no other state affected.
- Hazard/no-write: addr_a=addr_d=5 with wr_regfile=1 -> data_a shows old value before the edge and new value after; with wr_regfile=0 for several cycles while f/imm change -> regfile unchanged, only `result` tracks the ALU.

Source files
------------

// File: rtl/datapath.sv
// datapath: minimal integer datapath for the control unit.
//   NREGS x LENGTH register file (two async read ports, one sync write port),
//   a two-function ALU (LUI: pass imm, ADD: A+B modulo 2^LENGTH) and a single
//   registered result stage whose output is the register file write data.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high; clears every register and result
//   addr_a/b   - read addresses for operands A and B
//   addr_d     - destination address for the write port
//   wr_regfile - write enable; writes result into regfile[addr_d]
//   imm        - immediate operand
//   f          - function select: 1 = LUI, 0 = ADD
//   data_a/b   - combinational reads of regfile[addr_a] / regfile[addr_b]
//   result     - registered ALU output
module datapath #(
  parameter  int unsigned LENGTH   = 32,
  parameter  int unsigned NREGS    = 32,
  localparam int unsigned SEL_BITS = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SEL_BITS-1:0] addr_a,
  input  logic [SEL_BITS-1:0] addr_b,
  input  logic [SEL_BITS-1:0] addr_d,
  input  logic                wr_regfile,
  input  logic [LENGTH-1:0]   imm,
  input  logic                f,
  output logic [LENGTH-1:0]   data_a,
  output logic [LENGTH-1:0]   data_b,
  output logic [LENGTH-1:0]   result
);

  logic [LENGTH-1:0] r_regs [NREGS];
  logic [LENGTH-1:0] r_result;
  logic [LENGTH-1:0] w_alu;

  // No forwarding: a write to the address being read shows up only after the edge.
  assign data_a = r_regs[addr_a];
  assign data_b = r_regs[addr_b];
  assign result = r_result;

  // Carry out of the add is intentionally dropped.
  always_comb begin
    w_alu = data_a + data_b;
    if (f) begin
      w_alu = imm;
    end
  end

  // Write data is the previous cycle's ALU value held in r_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_result <= '0;
    end else begin
      r_result <= w_alu;
      if (wr_regfile) begin
        r_regs[addr_d] <= r_result;
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  localparam int L  = 32;
  localparam int NR = 32;
  localparam int SB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [SB-1:0] addr_a, addr_b, addr_d;
  logic          wr_regfile;
  logic [L-1:0]  imm;
  logic          f;
  logic [L-1:0]  data_a, data_b, result;

  datapath #(.LENGTH(L), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .wr_regfile(wr_regfile), .imm(imm), .f(f),
    .data_a(data_a), .data_b(data_b), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk_pre;
    logic [L-1:0] pre_a, pre_b;
    logic [L-1:0] post_r, post_a, post_b;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pushed   = 0;
  int popped   = 0;

  // Reference model state: architectural registers and the pending result.
  longint unsigned m_regs [NR];
  longint unsigned m_result;
  bit              m_known = 1'b0;

  task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One control-unit cycle: drive inputs after the falling edge, predict the
  // reads before the next rising edge and all outputs after it.
  task automatic cyc(input bit rst, input int a, input int b, input int d,
                     input bit we, input logic [L-1:0] im, input bit fn);
    exp_t e;
    longint unsigned alu;
    @(negedge clk);
    reset = rst; addr_a = SB'(a); addr_b = SB'(b); addr_d = SB'(d);
    wr_regfile = we; imm = im; f = fn;
    e.chk_pre = m_known;
    e.pre_a = L'(m_regs[a]);
    e.pre_b = L'(m_regs[b]);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_result = 0;
      m_known  = 1'b1;
    end else begin
      if (fn) alu = im;
      else    alu = (m_regs[a] + m_regs[b]) % (64'd1 << L);
      if (we) m_regs[d] = m_result;
      m_result = alu;
    end
    e.post_r = L'(m_result);
    e.post_a = L'(m_regs[a]);
    e.post_b = L'(m_regs[b]);
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: peeks the head before each edge, pops and compares after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0 && q[0].chk_pre) begin
        chk("pre_data_a", data_a, q[0].pre_a);
        chk("pre_data_b", data_b, q[0].pre_b);
      end
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        chk("result", result, e.post_r);
        chk("post_data_a", data_a, e.post_a);
        chk("post_data_b", data_b, e.post_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; addr_a = '0; addr_b = '0; addr_d = '0;
    wr_regfile = 1'b0; imm = '0; f = 1'b0;

    cyc(1, 0, 0, 0, 0, 32'h0, 0);
    // LUI into r0, then r1
    cyc(0, 0, 0, 0, 0, 32'hCAC00000, 1);
    cyc(0, 0, 0, 0, 1, 32'h0, 1);
    cyc(0, 0, 1, 0, 0, 32'h01000000, 1);
    cyc(0, 0, 1, 1, 1, 32'h0, 1);
    // ADD r0+r1 -> r2
    cyc(0, 0, 1, 0, 0, 32'h0, 0);
    cyc(0, 2, 1, 2, 1, 32'h0, 1);
    // wrap-around: r3=FFFFFFFF, r4=2, ADD -> 1
    cyc(0, 3, 4, 0, 0, 32'hFFFFFFFF, 1);
    cyc(0, 3, 4, 3, 1, 32'h0, 1);
    cyc(0, 3, 4, 0, 0, 32'h00000002, 1);
    cyc(0, 3, 4, 4, 1, 32'h0, 1);
    cyc(0, 3, 4, 0, 0, 32'h0, 0);
    cyc(0, 0, 2, 0, 0, 32'h0, 0);
    // hazard: read and write r5 in the same cycle
    cyc(0, 5, 2, 0, 0, 32'h5A5A1234, 1);
    cyc(0, 5, 5, 5, 1, 32'h0, 1);
    // no writes while f/imm change
    for (int i = 0; i < 6; i++)
      cyc(0, i, 5 - i, $urandom_range(0, NR - 1), 0, $urandom, i[0]);
    // reset with a simultaneous write
    cyc(0, 6, 5, 6, 1, 32'h0, 1);
    cyc(1, 6, 5, 6, 1, 32'h0, 1);
    cyc(0, 0, 1, 0, 0, 32'h0, 0);
    cyc(0, 2, 3, 0, 0, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL scoreboard_drain: popped %0d expected %0d (left %0d)", popped, pushed, q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
